uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
UART receive controller that turns the synchronised serial line into parallel bytes.
- Generates its own oversample tick, detects and validates the start bit, mid-bit samples each data bit and checks the stop bit.
- Presents each received word on a valid/ready output register.
- Feeds the downstream byte consumer; owns framing decisions so consumers see only complete words.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first, range 5..9
OVERSAMPLE, 8, oversample ticks per bit period, power of two, minimum 4
CLK_DIV, 4, clk cycles per oversample tick, minimum 1

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low
rx_in  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  received word, stable while data_valid=1
data_valid  output  1  word available
data_ready  input  1  consumer accepts word when data_valid & data_ready
frame_err  output  1  one-cycle pulse when stop bit sampled 0
overrun  output  1  one-cycle pulse when a new word lands while data_valid=1
parity_err  output  1  one-cycle pulse on parity mismatch (0 unless UART_RX_PARITY_EN)

Behaviour:
- Clock and reset: clk; reset synchronous, active-low. While reset=0:
  - FSM goes to IDLE; synchroniser flops go to 1; tick divider and oversample counter go to 0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, parity_err=0.
  - Reset mid-frame abandons the partial word with no error pulse.
- Input sync: rx_in passes through 2 flops (rx_s); all decisions use rx_s, giving 2 clk of latency.
- Tick: divider counts 0..CLK_DIV-1 and asserts tick for one clk at wrap. Divider runs freely outside reset.
- Oversample counter os_cnt, width log2(OVERSAMPLE), advances only on tick.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
  - IDLE: on a tick with rx_s=0, clear os_cnt and go to START.
  - START: on the tick where os_cnt reaches OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: clear os_cnt, bit_idx=0, go to DATA.
    - rx_s=1: glitch; return to IDLE silently.
  - DATA: on the tick where os_cnt reaches OVERSAMPLE-1:
    - Shift rx_s into the MSB of the shift register (right shift, LSB first).
    - bit_idx increments; after bit DATA_BITS-1 go to PARITY if enabled, otherwise STOP.
  - STOP: sample at os_cnt = OVERSAMPLE-1.
    - rx_s=1: load data_out, set data_valid the next cycle, go to IDLE.
    - rx_s=0: pulse frame_err, discard the word, go to WAIT_IDLE.
  - WAIT_IDLE: stay until a tick sees rx_s=1, then go to IDLE. A break condition must not generate repeated frames.
- Output handshake:
  - data_valid clears on the cycle after data_valid & data_ready.
  - data_out holds while data_valid=1 and ready=0.
  - A word completing while data_valid=1 overwrites data_out, keeps data_valid=1 and pulses overrun. Accept and complete in the same cycle: no overrun.
- Latency: from the rx_in falling edge at start to data_valid ≈ (DATA_BITS+1.5)·OVERSAMPLE·CLK_DIV + 3 clk, with ±CLK_DIV jitter.
- Frame error and overrun can never occur in the same cycle.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state after DATA samples one extra bit; even parity over data bits plus the parity bit.
  - Mismatch: parity_err pulses one cycle at the stop sample, the word is discarded, then normal STOP handling.
  - Framing is checked first; a frame error suppresses parity_err.
- Undefined: no PARITY state; parity_err tied to 0.

Decomposition:
- Package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
  - Default constants UART_DATA_BITS=8, UART_OVERSAMPLE=8, UART_CLK_DIV=4.
  - Helper function clog2-based width constants.
- Sub-module uart_baud_tick: divider producing the tick. It is reused by the future tx block.

Test Plan:
All cases use CLK_DIV=4 and OVERSAMPLE=8, so one bit is 32 clk.
- Send 0xA5 (8N1), data_ready=1 → one data_valid pulse, data_out=0xA5, frame_err=0.
- 8 clk low glitch on idle rx_in → no state change beyond START, data_valid stays 0.
- Send 0x3C with stop bit driven 0, then hold rx_in low 100 clk, then high → exactly one frame_err pulse, no data_valid, next frame 0x81 received correctly.
- data_ready=0, send 0x11 then 0x22 → overrun pulses once, data_out=0x22; raise ready → data_valid drops one cycle later.
- Assert reset=0 during bit 4 of 0xFF, release, send 0x5A → only 0x5A is received, with no error pulses.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 → data_valid, data_out=0x07. Send 0x07 with parity bit 0 → parity_err pulse, no data_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame/timing constants, counter width helper.
// Imported by the rx controller, its interface and the baud tick divider.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 8;
    localparam int UART_CLK_DIV    = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Counter width for a count range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-word valid/ready channel plus one-cycle status pulses; master = receiver, slave = byte consumer.
interface uart_rx_ctrl_if import uart_pkg::*; #(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 parity_err;

    modport master (
        output data_out, data_valid, frame_err, overrun, parity_err,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, frame_err, overrun, parity_err,
        output data_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running clk divider: one-cycle tick every CLK_DIV clocks, on the cycle the count wraps.
// Zero latency, no backpressure; shared with the transmit side.
module uart_baud_tick import uart_pkg::*; #(
    parameter int CLK_DIV = UART_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: start edge to data_valid ~(DATA_BITS+1.5) bit periods + 3 clk; UART_RX_PARITY_EN adds an even parity bit.
// An unaccepted word is held; a newer word overwrites it, keeps data_valid and pulses overrun.
module uart_rx_ctrl import uart_pkg::*; #(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int CLK_DIV    = UART_CLK_DIV
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx_in,
    uart_rx_ctrl_if.master rx
);

    localparam int               OS_W     = cnt_width(OVERSAMPLE);
    localparam int               BIT_W    = cnt_width(DATA_BITS);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 tick;
    rx_state_t            state, state_nxt;
    logic [OS_W-1:0]      os_cnt, os_nxt;
    logic [BIT_W-1:0]     bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 word_done;
    logic                 frame_hit;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_nxt;
    logic                 parity_hit;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        os_nxt    = os_cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        word_done = 1'b0;
        frame_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt    = par_bit;
        parity_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                os_nxt = '0;
                if (tick && !rx_s) state_nxt = START;
            end
            START: if (tick) begin
                if (os_cnt == OS_MID) begin
                    os_nxt    = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    os_nxt = os_cnt + 1'b1;
                end
            end
            // OVERSAMPLE is a power of two, so os_cnt wraps to 0 on the sampling tick.
            DATA: if (tick) begin
                os_nxt = os_cnt + 1'b1;
                if (os_cnt == OS_LAST) begin
                    shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_nxt   = bit_idx + 1'b1;
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                os_nxt = os_cnt + 1'b1;
                if (os_cnt == OS_LAST) begin
                    par_nxt   = rx_s;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: if (tick) begin
                os_nxt = os_cnt + 1'b1;
                if (os_cnt == OS_LAST) begin
                    if (!rx_s) begin
                        frame_hit = 1'b1;
                        state_nxt = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shreg, par_bit}) begin
                        parity_hit = 1'b1;
                        state_nxt  = IDLE;
`endif
                    end else begin
                        word_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            // Hold off until the line returns high so a break yields a single error.
            WAIT_IDLE: begin
                os_nxt = '0;
                if (tick && rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            os_cnt  <= os_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx.data_out   <= '0;
            rx.data_valid <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.overrun    <= 1'b0;
        end else begin
            rx.frame_err <= frame_hit;
            rx.overrun   <= word_done && rx.data_valid && !rx.data_ready;
            if (word_done) begin
                rx.data_out   <= shreg;
                rx.data_valid <= 1'b1;
            end else if (rx.data_ready) begin
                rx.data_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_bit       <= 1'b0;
            rx.parity_err <= 1'b0;
        end else begin
            par_bit       <= par_nxt;
            rx.parity_err <= parity_hit;
        end
    end
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl (CLK_DIV=4, OVERSAMPLE=8: 32 clk per bit): frame-level model of expected words/errors
// with a timing window, handshake model checked every cycle, plus literal checks after each directed scenario.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int BIT_CLK = 32;
`ifdef UART_RX_PARITY_EN
    localparam int NOM_LAT = 339;
`else
    localparam int NOM_LAT = 307;
`endif
    localparam int JIT     = 4;
    localparam int EV_NONE = 0;
    localparam int EV_WORD = 1;
    localparam int EV_FERR = 2;
    localparam int EV_PERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t_start;
        int         t_nom;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx_in = 1'b1;

    uart_rx_ctrl_if #(.DATA_BITS(8)) rx ();

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(8), .CLK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .rx_in (rx_in),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    exp_t       exp_q[$];
    int         word_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         ovr_cnt = 0;
    int         first_lat = -1;
    logic [7:0] last_word = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bits[0] is the start bit; sent LSB first, each held one bit period.
    task automatic send_raw(input logic [10:0] bits, input int nbits, input int kind, input logic [7:0] d);
        exp_t e;
        if (kind != EV_NONE) begin
            e.kind    = kind;
            e.data    = d;
            e.t_start = cyc;
            e.t_nom   = cyc + NOM_LAT;
            exp_q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            rx_in = bits[i];
            idle(BIT_CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int kind);
`ifdef UART_RX_PARITY_EN
        send_raw({stop_bit, ^d, d, 1'b0}, 11, kind, d);
`else
        send_raw({1'b0, stop_bit, d, 1'b0}, 10, kind, d);
`endif
    endtask

    // Per-cycle comparison against the frame/handshake model.
    logic       rst_q    = 1'b0;
    logic       pv_valid = 1'b0;
    logic       pv_ready = 1'b0;
    logic       pv_dv    = 1'b0;
    logic [7:0] pv_dout  = 8'h00;
    logic       m_valid  = 1'b0;
    logic [7:0] m_data   = 8'h00;

    always @(negedge clk) begin
        logic land;
        logic exp_ovr;
        int   kind;
        exp_t e;
        if (!rst_q) begin
            check("reset_data_valid", rx.data_valid, 0);
            check("reset_data_out", rx.data_out, 0);
            check("reset_frame_err", rx.frame_err, 0);
            check("reset_overrun", rx.overrun, 0);
            check("reset_parity_err", rx.parity_err, 0);
            m_valid  = 1'b0;
            pv_valid = 1'b0;
            pv_dv    = 1'b0;
            pv_dout  = 8'h00;
            pv_ready = rx.data_ready;
        end else begin
            if (pv_valid && pv_ready) m_valid = 1'b0;
            land    = rx.data_valid && (!pv_dv || rx.overrun || rx.data_out != pv_dout);
            exp_ovr = 1'b0;
            if (rx.overrun)    ovr_cnt++;
            if (rx.frame_err)  fe_cnt++;
            if (rx.parity_err) pe_cnt++;
            check("ferr_overrun_exclusive", rx.frame_err && rx.overrun, 0);
            if (land || rx.frame_err || rx.parity_err) begin
                kind = land ? EV_WORD : (rx.frame_err ? EV_FERR : EV_PERR);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d, expected no event (cycle %0d)", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", kind, e.kind);
                    check("event_time_in_window", (cyc >= e.t_nom - JIT) && (cyc <= e.t_nom + JIT), 1);
                    if (kind == EV_WORD) begin
                        exp_ovr = pv_valid && !pv_ready;
                        m_valid = 1'b1;
                        m_data  = e.data;
                        word_cnt++;
                        last_word = rx.data_out;
                        if (first_lat < 0) first_lat = cyc - e.t_start;
                    end
                end
            end
            check("overrun", rx.overrun, exp_ovr);
            check("data_valid", rx.data_valid, m_valid);
            if (m_valid) check("data_out", rx.data_out, m_data);
            if (exp_q.size() != 0 && cyc > exp_q[0].t_nom + JIT) begin
                checks++;
                errors++;
                $display("FAIL missing_event: kind %0d seen=0, required=1 by cycle %0d (now %0d)",
                         exp_q[0].kind, exp_q[0].t_nom + JIT, cyc);
                void'(exp_q.pop_front());
            end
            pv_valid = m_valid;
            pv_ready = rx.data_ready;
            pv_dv    = rx.data_valid;
            pv_dout  = rx.data_out;
        end
        rst_q = reset;
    end

    initial begin
        rx.data_ready = 1'b1;
        idle(10);
        check("lit_reset_valid", rx.data_valid, 0);
        reset = 1'b1;
        idle(40);

        // 0xA5 with consumer ready
        send_frame(8'hA5, 1'b1, EV_WORD);
        idle(64);
        check("lit_a5_count", word_cnt, 1);
        check("lit_a5_data", last_word, 8'hA5);
        check("lit_a5_no_ferr", fe_cnt, 0);
        check("lit_a5_latency", (first_lat >= NOM_LAT - JIT) && (first_lat <= NOM_LAT + JIT), 1);

        // 8 clk glitch: rejected at mid start bit
        rx_in = 1'b0;
        idle(8);
        rx_in = 1'b1;
        idle(400);
        check("lit_glitch_count", word_cnt, 1);
        check("lit_glitch_valid", rx.data_valid, 0);

        // bad stop bit followed by a break, then a clean frame
        send_frame(8'h3C, 1'b0, EV_FERR);
        idle(100);
        rx_in = 1'b1;
        idle(64);
        send_frame(8'h81, 1'b1, EV_WORD);
        idle(64);
        check("lit_break_ferr_once", fe_cnt, 1);
        check("lit_81_count", word_cnt, 2);
        check("lit_81_data", last_word, 8'h81);

        // consumer stalled across two words
        rx.data_ready = 1'b0;
        send_frame(8'h11, 1'b1, EV_WORD);
        idle(32);
        send_frame(8'h22, 1'b1, EV_WORD);
        idle(64);
        check("lit_overrun_once", ovr_cnt, 1);
        check("lit_overrun_data", rx.data_out, 8'h22);
        check("lit_overrun_valid_held", rx.data_valid, 1);
        rx.data_ready = 1'b1;
        idle(1);
        check("lit_accept_drops_valid", rx.data_valid, 0);

        // reset during bit 4 of 0xFF, then 0x5A
        idle(64);
        fork
            send_frame(8'hFF, 1'b1, EV_NONE);
            begin
                idle(BIT_CLK * 5 + 16);
                reset = 1'b0;
                idle(4);
                reset = 1'b1;
            end
        join
        idle(64);
        send_frame(8'h5A, 1'b1, EV_WORD);
        idle(64);
        check("lit_5a_count", word_cnt, 5);
        check("lit_5a_data", last_word, 8'h5A);
        check("lit_5a_no_ferr", fe_cnt, 1);
        check("lit_5a_no_perr", pe_cnt, 0);

`ifdef UART_RX_PARITY_EN
        send_raw({1'b1, 1'b1, 8'h07, 1'b0}, 11, EV_WORD, 8'h07);
        idle(64);
        check("lit_par_ok_count", word_cnt, 6);
        check("lit_par_ok_data", last_word, 8'h07);
        send_raw({1'b1, 1'b0, 8'h07, 1'b0}, 11, EV_PERR, 8'h07);
        idle(64);
        check("lit_par_err_once", pe_cnt, 1);
        check("lit_par_err_no_word", word_cnt, 6);
`endif

        idle(400);
        check("expectations_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
